// File: rtl/slave_msg_pkg.sv
// Shared definitions for the ping-pong slave message buffer.
//   - read address map constants (header words and payload base)
//   - write-side FSM state encoding
package slave_msg_pkg;

    localparam int unsigned HDR_CNT_H    = 0;
    localparam int unsigned HDR_CNT_L    = 1;
    localparam int unsigned HDR_LEN      = 2;
    localparam int unsigned HDR_CSUM     = 3;
    localparam int unsigned PAYLOAD_BASE = 4;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wr_state_e;

endpackage

// File: rtl/slave_msg_ram.sv
// Two-bank synchronous RAM, one write port and one read port.
// The bank select is the address MSB; the read has 1-cycle latency and
// returns the old contents on a same-address read/write collision.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   {bank, index} write address
//   wdata_i  in   write data
//   re_i     in   read enable (rdata_o holds when low)
//   raddr_i  in   {bank, index} read address
//   rdata_o  out  registered read data
module slave_msg_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W:0]   raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned WORDS = 2 << ADDR_W;

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Storage is intentionally not reset; stale words are masked by len.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/slave_msg_buffer.sv
// Ping-pong message buffer between the data generator and the master read bus.
// The writer fills one bank while the master reads the last committed message
// from the other through an address-mapped port (header words + payload).
// Optional build macro: SLAVE_MSG_CSUM_EN adds a per-message XOR checksum
// readable at address 3 (reads 0 when the macro is undefined).
// Ports:
//   clk, rst_l   clock, asynchronous active-low reset
//   wr_valid     in   write beat offered
//   wr_data      in   payload word
//   wr_ready     out  writer can accept a beat (from FSM state only)
//   new_msg      in   pulse that commits the message being filled
//   ram_rd_rq    in   read request
//   rd_addr      in   read address, sampled with ram_rd_rq
//   data_o       out  read data, 2 cycles after the request
//   data_valid   out  data_o holds the result of a request this cycle
//   ready        out  committed, unacknowledged message available
module slave_msg_buffer
    import slave_msg_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned RD_ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 wr_valid,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 wr_ready,
    input  logic                 new_msg,
    input  logic                 ram_rd_rq,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]    data_o,
    output logic                 data_valid,
    output logic                 ready
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned CNT_W = 2 * DATA_W;

    wr_state_e            state_q, state_d;
    logic                 beat_c;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, wr_ptr_inc_c;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     msg_cnt_q, msg_cnt_d;
    logic                 ready_q, ready_d;
    logic [DATA_W-1:0]    csum_hdr_c;

    // Read pipeline
    logic [RD_ADDR_W-1:0] pay_off_c;
    logic                 pay_hit_c;
    logic [DATA_W-1:0]    hdr_c;
    logic                 s1_vld_q, s1_pay_q;
    logic [DATA_W-1:0]    s1_hdr_q;
    logic [ADDR_W:0]      s1_raddr_q;
    logic                 s2_vld_q, s2_pay_q;
    logic [DATA_W-1:0]    s2_hdr_q;
    logic [DATA_W-1:0]    ram_rdata;
    logic [DATA_W-1:0]    data_q;
    logic                 data_valid_q;

    assign beat_c       = wr_valid && wr_ready;
    assign wr_ptr_inc_c = wr_ptr_q + PTR_W'(beat_c);

    // Write FSM: state register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM: next state; a commit always returns to FILL
    always_comb begin
        state_d = state_q;
        if (new_msg) begin
            state_d = FILL;
        end else if (state_q == FILL && wr_ptr_inc_c == PTR_W'(DEPTH)) begin
            state_d = FULL;
        end
    end

    // Write FSM: outputs
    always_comb begin
        wr_ready = 1'b0;
        if (state_q == FILL) begin
            wr_ready = 1'b1;
        end
    end

    // Message framing; len includes a beat accepted in the commit cycle
    always_comb begin
        wr_ptr_d  = wr_ptr_inc_c;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        len_d     = len_q;
        msg_cnt_d = msg_cnt_q;
        ready_d   = ready_q;
        if (ram_rd_rq && rd_addr == RD_ADDR_W'(HDR_CNT_H)) begin
            ready_d = 1'b0;
        end
        if (new_msg) begin
            wr_ptr_d  = '0;
            wr_bank_d = ~wr_bank_q;
            rd_bank_d = wr_bank_q;
            len_d     = wr_ptr_inc_c;
            msg_cnt_d = msg_cnt_q + CNT_W'(1);
            ready_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b1;
            len_q     <= '0;
            msg_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            len_q     <= len_d;
            msg_cnt_q <= msg_cnt_d;
            ready_q   <= ready_d;
        end
    end

`ifdef SLAVE_MSG_CSUM_EN
    logic [DATA_W-1:0] csum_run_q, csum_run_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] csum_beat_c;

    // Running XOR, with the commit-cycle beat folded into the latched value
    always_comb begin
        csum_beat_c = csum_run_q ^ (beat_c ? wr_data : '0);
        csum_run_d  = new_msg ? '0 : csum_beat_c;
        csum_d      = new_msg ? csum_beat_c : csum_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            csum_run_q <= '0;
            csum_q     <= '0;
        end else begin
            csum_run_q <= csum_run_d;
            csum_q     <= csum_d;
        end
    end

    assign csum_hdr_c = csum_q;
`else
    assign csum_hdr_c = '0;
`endif

    // Request decode; header, bank and len are frozen at the sampling edge
    // so a commit in the same cycle is invisible to this read.
    assign pay_off_c = rd_addr - RD_ADDR_W'(PAYLOAD_BASE);
    assign pay_hit_c = (rd_addr >= RD_ADDR_W'(PAYLOAD_BASE))
                    && (pay_off_c < RD_ADDR_W'(DEPTH))
                    && (pay_off_c < RD_ADDR_W'(len_q));

    always_comb begin
        hdr_c = '0;
        case (rd_addr)
            RD_ADDR_W'(HDR_CNT_H): hdr_c = msg_cnt_q[CNT_W-1:DATA_W];
            RD_ADDR_W'(HDR_CNT_L): hdr_c = msg_cnt_q[DATA_W-1:0];
            RD_ADDR_W'(HDR_LEN):   hdr_c = DATA_W'(len_q);
            RD_ADDR_W'(HDR_CSUM):  hdr_c = csum_hdr_c;
            default:               hdr_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_vld_q     <= 1'b0;
            s1_pay_q     <= 1'b0;
            s1_hdr_q     <= '0;
            s1_raddr_q   <= '0;
            s2_vld_q     <= 1'b0;
            s2_pay_q     <= 1'b0;
            s2_hdr_q     <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            s1_vld_q     <= ram_rd_rq;
            s1_pay_q     <= pay_hit_c;
            s1_hdr_q     <= hdr_c;
            s1_raddr_q   <= {rd_bank_q, pay_off_c[ADDR_W-1:0]};
            s2_vld_q     <= s1_vld_q;
            s2_pay_q     <= s1_pay_q;
            s2_hdr_q     <= s1_hdr_q;
            data_valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                data_q <= s2_pay_q ? ram_rdata : s2_hdr_q;
            end
        end
    end

    slave_msg_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (beat_c),
        .waddr_i ({wr_bank_q, wr_ptr_q[ADDR_W-1:0]}),
        .wdata_i (wr_data),
        .re_i    (s1_vld_q && s1_pay_q),
        .raddr_i (s1_raddr_q),
        .rdata_o (ram_rdata)
    );

    assign data_o     = data_q;
    assign data_valid = data_valid_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_slave_msg_buffer.sv
// Directed self-checking bench for slave_msg_buffer (default parameters).
module tb_slave_msg_buffer;

    logic        clk;
    logic        rst_l;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        new_msg;
    logic        ram_rd_rq;
    logic [15:0] rd_addr;
    logic [7:0]  data_o;
    logic        data_valid;
    logic        ready;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl1 [8];
    vec_t tbl2 [4];

    slave_msg_buffer dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .new_msg    (new_msg),
        .ram_rd_rq  (ram_rd_rq),
        .rd_addr    (rd_addr),
        .data_o     (data_o),
        .data_valid (data_valid),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_beat(input logic [7:0] d, input logic commit);
        wr_valid = 1'b1;
        wr_data  = d;
        new_msg  = commit;
        tick();
        wr_valid = 1'b0;
        new_msg  = 1'b0;
    endtask

    task automatic commit();
        new_msg = 1'b1;
        tick();
        new_msg = 1'b0;
    endtask

    // Single isolated read: request sampled at the next edge, result 2 edges later
    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        ram_rd_rq = 1'b1;
        rd_addr   = a;
        tick();
        ram_rd_rq = 1'b0;
        tick();
        tick();
        check({name, "_valid"}, 32'(data_valid), 32'd1);
        check(name, 32'(data_o), 32'(exp));
    endtask

    initial begin
        logic [7:0] exp_csum;

        tbl1[0] = '{16'd0, 8'h00};
        tbl1[1] = '{16'd1, 8'h01};
        tbl1[2] = '{16'd2, 8'h03};
        tbl1[3] = '{16'd3, 8'h00};
        tbl1[4] = '{16'd4, 8'h11};
        tbl1[5] = '{16'd5, 8'h22};
        tbl1[6] = '{16'd6, 8'h33};
        tbl1[7] = '{16'd7, 8'h00};

        tbl2[0] = '{16'd4, 8'hA1};
        tbl2[1] = '{16'd5, 8'hA2};
        tbl2[2] = '{16'd6, 8'hA3};
        tbl2[3] = '{16'd7, 8'h44};

        rst_l     = 1'b1;
        wr_valid  = 1'b0;
        wr_data   = '0;
        new_msg   = 1'b0;
        ram_rd_rq = 1'b0;
        rd_addr   = '0;
        #1 rst_l  = 1'b0;
        tick();
        tick();
        check("rst_data_o", 32'(data_o), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        rst_l = 1'b1;
        tick();

        // Basic message, then back-to-back header + payload reads
        write_beat(8'h11, 1'b0);
        write_beat(8'h22, 1'b0);
        write_beat(8'h33, 1'b0);
        check("ready_before_commit", 32'(ready), 32'd0);
        commit();
        check("ready_after_commit", 32'(ready), 32'd1);
        for (int j = 0; j < 11; j++) begin
            ram_rd_rq = (j < 8);
            rd_addr   = (j < 8) ? tbl1[j].addr : 16'd0;
            tick();
            if (j >= 2 && j < 10) begin
                check($sformatf("b2b_valid_%0d", j - 2), 32'(data_valid), 32'd1);
                check($sformatf("b2b_addr_%0d", tbl1[j-2].addr), 32'(data_o), 32'(tbl1[j-2].exp));
            end else begin
                check($sformatf("b2b_idle_%0d", j), 32'(data_valid), 32'd0);
            end
        end
        ram_rd_rq = 1'b0;
        check("ready_cleared_by_ack", 32'(ready), 32'd0);

        // Fill a whole bank, then push one more beat into a full buffer
        for (int i = 0; i < 128; i++) begin
            write_beat(8'(i * 3 + 1), 1'b0);
            if (i == 126) check("wr_ready_at_127", 32'(wr_ready), 32'd1);
        end
        check("wr_ready_full", 32'(wr_ready), 32'd0);
        write_beat(8'hEE, 1'b0);
        check("wr_ready_still_full", 32'(wr_ready), 32'd0);
        commit();
        check("wr_ready_after_commit", 32'(wr_ready), 32'd1);
        rd_chk("full_len", 16'd2, 8'h80);
        rd_chk("full_cnt_l", 16'd1, 8'h02);
        rd_chk("full_first", 16'd4, 8'h01);
        rd_chk("full_last", 16'd131, 8'h7E);
        rd_chk("full_oor", 16'd132, 8'h00);

        // Commit in the same cycle as the 4th beat
        write_beat(8'hA1, 1'b0);
        write_beat(8'hA2, 1'b0);
        write_beat(8'hA3, 1'b0);
        write_beat(8'h44, 1'b1);
        rd_chk("same_cyc_len", 16'd2, 8'h04);
        rd_chk("same_cyc_pay3", 16'd7, 8'h44);
        rd_chk("same_cyc_beyond_len", 16'd8, 8'h00);
`ifdef SLAVE_MSG_CSUM_EN
        exp_csum = 8'hE4;
`else
        exp_csum = 8'h00;
`endif
        rd_chk("same_cyc_csum", 16'd3, exp_csum);
        // data_o holds when idle
        tick();
        tick();
        check("hold_valid", 32'(data_valid), 32'd0);
        check("hold_data", 32'(data_o), 32'(exp_csum));

        // Fill the other bank while re-reading the committed one
        for (int i = 0; i < 4; i++) begin
            write_beat(8'h99, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h5C;
            rd_chk($sformatf("bankA_addr_%0d", tbl2[i].addr), tbl2[i].addr, tbl2[i].exp);
        end
        wr_valid = 1'b0;

        // Message counter wrap; cnt is 3 here, advance to 0xFFFF
        new_msg = 1'b1;
        for (int i = 0; i < 65532; i++) begin
            tick();
        end
        new_msg = 1'b0;
        rd_chk("cnt_ffff_h", 16'd0, 8'hFF);
        rd_chk("cnt_ffff_l", 16'd1, 8'hFF);
        // Commit together with an address-0 read: commit wins, read sees old count
        new_msg   = 1'b1;
        ram_rd_rq = 1'b1;
        rd_addr   = 16'd0;
        tick();
        new_msg   = 1'b0;
        ram_rd_rq = 1'b0;
        check("commit_beats_ack", 32'(ready), 32'd1);
        tick();
        tick();
        check("collide_read_old", 32'(data_o), 32'hFF);
        rd_chk("cnt_wrap_h", 16'd0, 8'h00);
        rd_chk("cnt_wrap_l", 16'd1, 8'h00);
        rd_chk("zero_len", 16'd2, 8'h00);

        // Reset with a read in flight
        write_beat(8'h77, 1'b1);
        ram_rd_rq = 1'b1;
        rd_addr   = 16'd4;
        tick();
        ram_rd_rq = 1'b0;
        rst_l     = 1'b0;
        #1;
        check("rst_flight_valid0", 32'(data_valid), 32'd0);
        check("rst_flight_ready", 32'(ready), 32'd0);
        tick();
        check("rst_flight_valid1", 32'(data_valid), 32'd0);
        rst_l = 1'b1;
        tick();
        check("rst_flight_valid2", 32'(data_valid), 32'd0);
        check("rst_flight_data", 32'(data_o), 32'd0);
        rd_chk("rst_payload", 16'd4, 8'h00);
        rd_chk("rst_cnt_l", 16'd1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
